wk_schedule_gen: RTL and testbench
==================================

WK_SCHEDULE_GEN -- requirements
Module: wk_schedule_gen

Parameters
REQ-001 The block SHALL have parameter WK_LENGTH, default 64, the number of rounds per block; only 64 is supported.

Interface
REQ-002 The block SHALL have port clock, input, 1 bit: rising-edge clock.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit: begin schedule for msg_block; sampled only in IDLE or DONE.
REQ-005 The block SHALL have port msg_block, input, 512 bits: padded block; word 0 = msg_block[511:480], big-endian.
REQ-006 The block SHALL have port enable, output, 1 bit: round consumer enable; low = consumer reloads its previous hash.
REQ-007 The block SHALL have port cur_w, output, 32 bits: W[t] for the current round.
REQ-008 The block SHALL have port cur_k, output, 32 bits: K[t] round constant.
REQ-009 The block SHALL have port wk_vector_index, output, $clog2(WK_LENGTH) bits: current round t.
REQ-010 The block SHALL have port wk_index_complete, output, 1 bit: final round is in progress or has finished.

Function
REQ-011 The block SHALL implement states IDLE, RUN and DONE.
REQ-012 Transitions SHALL be: IDLE->RUN on start; RUN->DONE after round 63 is presented; DONE->RUN on start; DONE->IDLE is never taken.
REQ-013 On start, the block SHALL load a 16-word window from msg_block and set t=0; the first RUN cycle SHALL present t=0, so latency start->first W is 1 cycle.
REQ-014 In RUN, the block SHALL present exactly one (W[t], K[t], t) per cycle and increment t by 1 each cycle; 64 RUN cycles per block.
REQ-015 For t<16, W[t] SHALL equal message word t.
REQ-016 For t>=16, W[t] SHALL equal s1(W[t-2])+W[t-7]+s0(W[t-15])+W[t-16] mod 2^32, where:
- s0 = ROTR7 ^ ROTR18 ^ SHR3
- s1 = ROTR17 ^ ROTR19 ^ SHR10
REQ-017 W generation SHALL use the 16-word sliding window (shift by one word per round); no 64-word storage.
REQ-018 cur_k SHALL come from a 64-entry constant table of FIPS 180-4 SHA-256 constants indexed by t.
REQ-019 Outputs SHALL be registered; cur_w, cur_k and wk_vector_index SHALL change only at clock edges.
REQ-020 enable SHALL be 0 in IDLE and 1 in RUN and DONE.
REQ-021 wk_index_complete SHALL be 1 in the RUN cycle with t=63 and stay 1 throughout DONE.
REQ-022 wk_index_complete SHALL clear in the first RUN cycle after a restart.
REQ-023 In DONE, cur_w, cur_k and wk_vector_index SHALL hold their t=63 values.
REQ-024 start asserted while in RUN SHALL be ignored; the schedule in progress SHALL not be disturbed.
REQ-025 A start in DONE SHALL reload msg_block, giving back-to-back blocks with no IDLE gap.
REQ-026 wk_vector_index SHALL never wrap past 63 within a block.

Reset
REQ-027 When reset is high at a clock edge, the block SHALL go to IDLE and set enable=0, wk_index_complete=0, cur_w=0, cur_k=0, wk_vector_index=0, and window=0.
REQ-028 Reset SHALL take priority over start; reset in mid-RUN SHALL abort the block with no further rounds presented.

Configuration
REQ-029 When macro WK_SCHEDULE_STALL_EN is defined, the block SHALL add input wk_stall (1 bit).
REQ-030 With WK_SCHEDULE_STALL_EN defined, wk_stall=1 in RUN SHALL freeze t, the window and all outputs for that cycle, and start during a stall SHALL be ignored.
REQ-031 With WK_SCHEDULE_STALL_EN defined, wk_stall SHALL have no effect in IDLE or DONE.
REQ-032 With WK_SCHEDULE_STALL_EN undefined, the block SHALL have no wk_stall port and SHALL advance every RUN cycle.

Verification
REQ-033 Bench SHALL cover the "abc" block (0x61626380, zeros, word15=0x00000018): required t=0 W=0x61626380 K=0x428A2F98; t=15 W=0x00000018; t=16 W=0x61626380; t=17 W=0x000F0000; t=63 K=0xC67178F2 with wk_index_complete=1.
REQ-034 Bench SHALL cover one-cycle start pulse in IDLE: required enable=0 before start, enable=1 from next cycle, exactly 64 RUN cycles, then DONE with outputs held.
REQ-035 Bench SHALL cover start held high through RUN: required t sequence 0..63 uninterrupted, no reload mid-block.
REQ-036 Bench SHALL cover reset at t=30: required next cycle enable=0, index=0, W=0, K=0, complete=0, state IDLE.
REQ-037 Bench SHALL cover start in DONE with a new block: required complete drops, t=0 W = new word 0 one cycle later.
REQ-038 Bench SHALL cover, with WK_SCHEDULE_STALL_EN defined, wk_stall=1 for 3 cycles at t=20: required t=20 and W[20] held 4 cycles, then t=21 correct.

Source files
------------

// File: rtl/wk_schedule_gen.sv
// SHA-256 message schedule: streams W[t]/K[t] for 64 rounds from a 16-word sliding window.
// Optional macro WK_SCHEDULE_STALL_EN adds a wk_stall input that freezes the schedule while in RUN.
module wk_schedule_gen #(
  parameter int WK_LENGTH = 64
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         start,
  input  logic [511:0]                 msg_block,
`ifdef WK_SCHEDULE_STALL_EN
  input  logic                         wk_stall,
`endif
  output logic                         enable,
  output logic [31:0]                  cur_w,
  output logic [31:0]                  cur_k,
  output logic [$clog2(WK_LENGTH)-1:0] wk_vector_index,
  output logic                         wk_index_complete
);

  localparam int TW = $clog2(WK_LENGTH);
  localparam logic [TW-1:0] LAST = TW'(WK_LENGTH - 1);

  localparam logic [31:0] K_TABLE [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic [15:0][31:0]  window_q, window_d;
  logic [TW-1:0]      t_q, t_d;
  logic [31:0]        k_q, k_d;
  logic               en_q, en_d;
  logic               cpl_q, cpl_d;
  logic               stall;
  logic [31:0]        w_new;

`ifdef WK_SCHEDULE_STALL_EN
  assign stall = wk_stall;
`else
  assign stall = 1'b0;
`endif

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  // window_q[i] holds W[t+i]; the word entering the window is W[t+16].
  assign w_new = sig1(window_q[14]) + window_q[9] + sig0(window_q[1]) + window_q[0];

  always_comb begin
    state_d  = state_q;
    window_d = window_q;
    t_d      = t_q;
    k_d      = k_q;
    en_d     = en_q;
    cpl_d    = cpl_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          for (int i = 0; i < 16; i++) begin
            window_d[i] = msg_block[511 - 32*i -: 32];
          end
          t_d   = '0;
          k_d   = K_TABLE[0];
          en_d  = 1'b1;
          cpl_d = 1'b0;
        end
      end
      RUN: begin
        if (!stall) begin
          if (t_q == LAST) begin
            state_d = DONE;
          end else begin
            window_d = {w_new, window_q[15:1]};
            t_d      = t_q + TW'(1);
            k_d      = K_TABLE[t_d];
            cpl_d    = (t_d == LAST);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      window_q <= '0;
      t_q      <= '0;
      k_q      <= '0;
      en_q     <= 1'b0;
      cpl_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      window_q <= window_d;
      t_q      <= t_d;
      k_q      <= k_d;
      en_q     <= en_d;
      cpl_q    <= cpl_d;
    end
  end

  assign enable            = en_q;
  assign cur_w             = window_q[0];
  assign cur_k             = k_q;
  assign wk_vector_index   = t_q;
  assign wk_index_complete = cpl_q;

endmodule

// File: tb/tb_wk_schedule_gen.sv
// Randomized bench for wk_schedule_gen against a whole-block SHA-256 schedule model.
// Build with WK_SCHEDULE_STALL_EN defined to also exercise wk_stall.
module tb_wk_schedule_gen;

  logic         clock = 1'b0;
  logic         reset;
  logic         start;
  logic [511:0] msg_block;
  logic         stall_in;
  logic         enable;
  logic [31:0]  cur_w;
  logic [31:0]  cur_k;
  logic [5:0]   wk_vector_index;
  logic         wk_index_complete;

  always #5 clock = ~clock;

  wk_schedule_gen #(.WK_LENGTH(64)) dut (
    .clock             (clock),
    .reset             (reset),
    .start             (start),
    .msg_block         (msg_block),
`ifdef WK_SCHEDULE_STALL_EN
    .wk_stall          (stall_in),
`endif
    .enable            (enable),
    .cur_w             (cur_w),
    .cur_k             (cur_k),
    .wk_vector_index   (wk_vector_index),
    .wk_index_complete (wk_index_complete)
  );

  localparam logic [31:0] K_REF [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Model: mode 0 idle, 1 run, 2 done; the full 64-word schedule is computed up front.
  int          m_mode  = 0;
  int          m_t     = 0;
  bit          m_valid = 1'b0;
  logic [31:0] m_W [64];

  always @(posedge clock) begin
    if (reset) begin
      m_mode  = 0;
      m_t     = 0;
      m_valid = 1'b1;
    end else if (m_valid) begin
      if (m_mode == 1) begin
        if (!stall_in || !`ifdef WK_SCHEDULE_STALL_EN 1'b1 `else 1'b0 `endif) begin
          if (m_t == 63) m_mode = 2;
          else m_t = m_t + 1;
        end
      end else if (start) begin
        for (int i = 0; i < 16; i++) m_W[i] = msg_block[511 - 32*i -: 32];
        for (int i = 16; i < 64; i++)
          m_W[i] = (rr(m_W[i-2], 17) ^ rr(m_W[i-2], 19) ^ (m_W[i-2] >> 10)) + m_W[i-7]
                 + (rr(m_W[i-15], 7) ^ rr(m_W[i-15], 18) ^ (m_W[i-15] >> 3)) + m_W[i-16];
        m_mode = 1;
        m_t    = 0;
      end
    end
  end

  always @(negedge clock) begin
    if (m_valid) begin
      if (m_mode == 0) begin
        check32("enable", {31'b0, enable}, 32'd0);
        check32("cur_w", cur_w, 32'd0);
        check32("cur_k", cur_k, 32'd0);
        check32("index", {26'b0, wk_vector_index}, 32'd0);
        check32("complete", {31'b0, wk_index_complete}, 32'd0);
      end else begin
        check32("enable", {31'b0, enable}, 32'd1);
        check32("cur_w", cur_w, m_W[m_t]);
        check32("cur_k", cur_k, K_REF[m_t]);
        check32("index", {26'b0, wk_vector_index}, m_t);
        check32("complete", {31'b0, wk_index_complete}, (m_t == 63) ? 32'd1 : 32'd0);
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_mode(input int mode, input string name);
    for (int i = 0; i < 400; i++) begin
      if (m_mode == mode) return;
      step();
    end
    n_checks++;
    n_fail++;
    $display("FAIL %s: timeout waiting for mode %0d, still %0d", name, mode, m_mode);
  endtask

  task automatic wait_t(input int t, input string name);
    for (int i = 0; i < 400; i++) begin
      if (m_mode == 1 && m_t == t) return;
      step();
    end
    n_checks++;
    n_fail++;
    $display("FAIL %s: timeout waiting for t=%0d, at %0d", name, t, m_t);
  endtask

  task automatic rand_block();
    for (int i = 0; i < 16; i++) msg_block[511 - 32*i -: 32] = $urandom;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    stall_in  = 1'b0;
    msg_block = '0;
    repeat (2) step();
    reset = 1'b0;
    @(negedge clock);
    check32("idle_enable", {31'b0, enable}, 32'd0);
    step();

    // "abc" block with literal expectations
    msg_block = {32'h61626380, 448'b0, 32'h00000018};
    pulse_start();
    for (int i = 0; i < 64; i++) begin
      @(negedge clock);
      if (i == 0) begin
        check32("abc_en0", {31'b0, enable}, 32'd1);
        check32("abc_w0", cur_w, 32'h61626380);
        check32("abc_k0", cur_k, 32'h428a2f98);
      end
      if (i == 15) check32("abc_w15", cur_w, 32'h00000018);
      if (i == 16) check32("abc_w16", cur_w, 32'h61626380);
      if (i == 17) check32("abc_w17", cur_w, 32'h000f0000);
      if (i == 63) begin
        check32("abc_k63", cur_k, 32'hc67178f2);
        check32("abc_cpl63", {31'b0, wk_index_complete}, 32'd1);
      end
    end
    check32("model_w17", m_W[17], 32'h000f0000);
    repeat (5) step();
    @(negedge clock);
    check32("done_index", {26'b0, wk_vector_index}, 32'd63);
    check32("done_k", cur_k, 32'hc67178f2);
    check32("done_cpl", {31'b0, wk_index_complete}, 32'd1);

    // restart from DONE with a new block
    step();
    rand_block();
    pulse_start();
    @(negedge clock);
    check32("restart_cpl", {31'b0, wk_index_complete}, 32'd0);
    check32("restart_w0", cur_w, msg_block[511:480]);
    check32("restart_idx", {26'b0, wk_vector_index}, 32'd0);
    wait_mode(2, "restart_done");

    // start held high through an entire block
    rand_block();
    start = 1'b1;
    repeat (64) begin
      step();
      rand_block();
    end
    start = 1'b0;
    @(negedge clock);
    check32("held_idx", {26'b0, wk_vector_index}, 32'd63);
    check32("held_cpl", {31'b0, wk_index_complete}, 32'd1);

    // reset in the middle of a block
    step();
    rand_block();
    pulse_start();
    wait_t(30, "reset_t30");
    reset = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clock);
    check32("rst_en", {31'b0, enable}, 32'd0);
    check32("rst_idx", {26'b0, wk_vector_index}, 32'd0);
    check32("rst_w", cur_w, 32'd0);
    check32("rst_k", cur_k, 32'd0);
    check32("rst_cpl", {31'b0, wk_index_complete}, 32'd0);
    repeat (3) step();

`ifdef WK_SCHEDULE_STALL_EN
    rand_block();
    pulse_start();
    wait_t(20, "stall_t20");
    stall_in = 1'b1;
    repeat (3) step();
    stall_in = 1'b0;
    @(negedge clock);
    check32("stall_idx20", {26'b0, wk_vector_index}, 32'd20);
    check32("stall_w20", cur_w, m_W[20]);
    @(negedge clock);
    check32("stall_idx21", {26'b0, wk_vector_index}, 32'd21);
    check32("stall_w21", cur_w, m_W[21]);
    wait_mode(2, "stall_done");
`endif

    // random blocks with start noise, msg churn and (if present) random stalls
    for (int b = 0; b < 6; b++) begin
      rand_block();
      pulse_start();
      for (int c = 0; c < 300 && m_mode == 1; c++) begin
        start = ($urandom_range(0, 3) == 0) && (m_mode == 1) && (m_t < 60);
        stall_in = ($urandom_range(0, 4) == 0);
        if ($urandom_range(0, 3) == 0) rand_block();
        step();
      end
      start = 1'b0;
      stall_in = $urandom_range(0, 1) == 1;
      wait_mode(2, "rand_done");
      repeat ($urandom_range(0, 3)) step();
    end
    stall_in = 1'b0;
    repeat (2) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
